// File: rtl/univ_shift_ctrl_if.sv
// Command and register-control bundle between univ_shift_ctrl and its surroundings.
// The master side issues commands and hosts the shift register; the slave side is the controller.
interface univ_shift_ctrl_if #(
  parameter int N  = 4,
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_amt;
  logic [N-1:0]  cmd_data;
  logic          abort;
  logic [N-1:0]  Q;
  logic [1:0]    s;
  logic          MSB_in;
  logic          LSB_in;
  logic [N-1:0]  I;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, abort, Q,
    input  cmd_ready, s, MSB_in, LSB_in, I, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, abort, Q,
    output cmd_ready, s, MSB_in, LSB_in, I, busy, done
  );
endinterface

// File: rtl/univ_shift_ctrl.sv
// Sequencer for a 4-mode universal shift register: parallel load, amt shift steps,
// then a one-cycle done pulse. Rotate fill comes from the register's Q feedback.
module univ_shift_ctrl #(
  parameter int N  = 4,
  parameter int AW = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  univ_shift_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [1:0]    r_op;
  logic [AW-1:0] r_cnt;
  logic [N-1:0]  r_i;

  logic [1:0]    w_s;
  logic          w_msb_in;
  logic          w_lsb_in;

  // State, captured command and load data
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_op    <= 2'b00;
      r_cnt   <= '0;
      r_i     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_op    <= bus.cmd_op;
            r_cnt   <= bus.cmd_amt;
            r_i     <= bus.cmd_data;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.abort)
            r_state <= ST_IDLE;
          else if (r_cnt != '0)
            r_state <= ST_SHIFT;
          else
            r_state <= ST_DONE;
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - AW'(1);
            if (r_cnt == AW'(1))
              r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Register mode and fill bits; op[0] selects left vs right, op[1] selects rotate
  always_comb begin
    w_s      = 2'b00;
    w_msb_in = 1'b0;
    w_lsb_in = 1'b0;
    case (r_state)
      ST_LOAD:  w_s = 2'b11;
      ST_SHIFT: begin
        if (r_op[0]) begin
          w_s      = 2'b10;
          w_lsb_in = r_op[1] ? bus.Q[N-1] : 1'b0;
        end else begin
          w_s      = 2'b01;
          w_msb_in = r_op[1] ? bus.Q[0] : 1'b0;
        end
      end
      default:  w_s = 2'b00;
    endcase
  end

  assign bus.s         = w_s;
  assign bus.MSB_in    = w_msb_in;
  assign bus.LSB_in    = w_lsb_in;
  assign bus.I         = r_i;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.cmd_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_univ_shift_ctrl.sv
// Bench for univ_shift_ctrl with a behavioural universal shift register attached.
module tb_univ_shift_ctrl;
  localparam int N  = 4;
  localparam int AW = 3;

  logic         clk;
  logic         reset;
  logic [N-1:0] q_reg;
  int           n_vec;
  int           n_err;

  univ_shift_ctrl_if #(.N(N), .AW(AW)) bus ();

  univ_shift_ctrl #(.N(N), .AW(AW)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The attached register: 00 hold, 01 shift right, 10 shift left, 11 load
  always_ff @(posedge clk) begin
    case (bus.s)
      2'b01:   q_reg <= {bus.MSB_in, q_reg[N-1:1]};
      2'b10:   q_reg <= {q_reg[N-2:0], bus.LSB_in};
      2'b11:   q_reg <= bus.I;
      default: q_reg <= q_reg;
    endcase
  end
  assign bus.Q = q_reg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value after k single-bit steps, computed arithmetically
  function automatic logic [3:0] ref_shift(input logic [3:0] d, input logic [1:0] op, input int k);
    logic [7:0] dd;
    int r;
    dd = {d, d};
    r  = k % 4;
    case (op)
      2'b00:   ref_shift = (k >= 4) ? 4'd0 : (d >> k);
      2'b01:   ref_shift = (k >= 4) ? 4'd0 : 4'(d << k);
      2'b10:   begin dd = dd >> r; ref_shift = dd[3:0]; end
      default: begin dd = dd << r; ref_shift = dd[7:4]; end
    endcase
  endfunction

  // Issue one command and check every cycle; abort_cyc>0 raises abort during that cycle
  task automatic run_cmd(input logic [1:0] op, input int amt, input logic [3:0] data,
                         input int abort_cyc, input bit hold);
    logic [3:0] cur;
    logic [1:0] sh;
    sh = op[0] ? 2'b10 : 2'b01;
    chk("ready_pre", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_amt   = AW'(amt);
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = ~data;
    end
    for (int c = 1; c <= amt + 2; c++) begin
      @(negedge clk);
      chk("I_hold", 32'(bus.I), 32'(data));
      chk("busy", 32'(bus.busy), 32'd1);
      chk("ready_busy", 32'(bus.cmd_ready), 32'd0);
      if (c >= 2) chk("Q_step", 32'(q_reg), 32'(ref_shift(data, op, c - 2)));
      if (c == 1) begin
        chk("s_load", 32'(bus.s), 32'd3);
        chk("done_early", 32'(bus.done), 32'd0);
      end else if (c <= amt + 1) begin
        cur = ref_shift(data, op, c - 2);
        chk("s_shift", 32'(bus.s), 32'(sh));
        chk("done_early", 32'(bus.done), 32'd0);
        chk("msb_in", 32'(bus.MSB_in), (op == 2'b10) ? 32'(cur[0]) : 32'd0);
        chk("lsb_in", 32'(bus.LSB_in), (op == 2'b11) ? 32'(cur[3]) : 32'd0);
      end else begin
        chk("s_done", 32'(bus.s), 32'd0);
        chk("done", 32'(bus.done), 32'd1);
        chk("Q_final", 32'(q_reg), 32'(ref_shift(data, op, amt)));
      end
      if (abort_cyc == c) begin
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_s", 32'(bus.s), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_Q", 32'(q_reg), 32'(ref_shift(data, op, (c >= 2) ? c - 1 : 0)));
        return;
      end
    end
    @(negedge clk);
    chk("ready_post", 32'(bus.cmd_ready), 32'd1);
    chk("done_post", 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    q_reg = '0;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_amt   = '0;
    bus.cmd_data  = '0;
    bus.abort     = 1'b0;

    // Reset with no clock edge: outputs settle immediately
    #1 reset = 1'b1;
    #2;
    chk("rst_s", 32'(bus.s), 32'd0);
    chk("rst_I", 32'(bus.I), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_fill", 32'({bus.MSB_in, bus.LSB_in}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(2'b10, 1, 4'b1011, 0, 1'b0);
    run_cmd(2'b01, 2, 4'b1011, 0, 1'b0);
    run_cmd(2'b11, 4, 4'b1011, 0, 1'b0);

    // amt=0 with cmd_valid held: re-accepted only once ready returns
    run_cmd(2'b00, 0, 4'b1111, 0, 1'b1);
    @(negedge clk);
    chk("hold_reload", 32'(bus.s), 32'd3);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_done", 32'(bus.done), 32'd1);
    chk("hold_Q", 32'(q_reg), 32'hF);
    @(negedge clk);

    // Abort on the second shift edge (end of cycle 3)
    run_cmd(2'b00, 5, 4'b1000, 3, 1'b0);
    chk("abort_Q_plan", 32'(q_reg), 32'b0010);
    run_cmd(2'b01, 3, 4'b0111, 1, 1'b0);

    // Reset pulse mid-SHIFT
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    bus.cmd_amt   = AW'(3);
    bus.cmd_data  = 4'b0110;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_shift", 32'(bus.s), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_s", 32'(bus.s), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_I", 32'(bus.I), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    chk("mid_rst_nodone", 32'(bus.done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_nodone", 32'(bus.done), 32'd0);
    run_cmd(2'b11, 3, 4'b0110, 0, 1'b0);

    // Randomized commands, including occasional aborts
    for (int t = 0; t < 40; t++) begin
      logic [1:0] op;
      logic [3:0] d;
      int a;
      int ab;
      op = 2'($urandom_range(3, 0));
      d  = 4'($urandom);
      a  = int'($urandom_range(7, 0));
      ab = ($urandom_range(4, 0) == 0) ? int'($urandom_range(a + 1, 1)) : 0;
      run_cmd(op, a, d, ab, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
